// File: rtl/line_segment_finder.sv
// Scans a pixel stream for horizontal runs of asserted pulse_in and emits each
// run at least MIN_RUN pixels long as a (start, end, line) segment over a valid/ready port.
module line_segment_finder #(
  parameter int X_W     = 11,
  parameter int Y_W     = 10,
  parameter int MIN_RUN = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           sof,
  input  logic           eol,
  input  logic           pulse_in,
  input  logic           seg_ready,
  output logic           seg_valid,
  output logic [X_W-1:0] seg_x_start,
  output logic [X_W-1:0] seg_x_end,
  output logic [Y_W-1:0] seg_y,
  output logic           overflow
);

  typedef enum logic {IDLE, IN_RUN} state_t;

  state_t         state, state_nxt;
  logic [X_W-1:0] x_reg, x_cur;
  logic [Y_W-1:0] y_reg, y_cur;
  logic [X_W-1:0] run_start, start_nxt;
  logic [Y_W-1:0] y_run, y_run_nxt;
  logic           in_run_eff;
  logic           close;
  logic [X_W-1:0] close_start, close_end;
  logic [Y_W-1:0] close_y;
  logic [X_W:0]   run_len;
  logic           qualify, load, drop;

  // x_reg/y_reg hold the position the next ce pixel will take; sof overrides it.
  assign x_cur = sof ? '0 : x_reg;
  assign y_cur = sof ? '0 : y_reg;

  // A sof pixel abandons any open run and is treated as if arriving in IDLE.
  assign in_run_eff = (state == IN_RUN) && !sof;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (ce) begin
      if (eol) begin
        x_reg <= '0;
        y_reg <= (y_cur != '1) ? y_cur + 1'b1 : y_cur;
      end else begin
        x_reg <= (x_cur != '1) ? x_cur + 1'b1 : x_cur;
        y_reg <= y_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      run_start <= '0;
      y_run     <= '0;
    end else if (ce) begin
      state     <= state_nxt;
      run_start <= start_nxt;
      y_run     <= y_run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = run_start;
    y_run_nxt = y_run;
    if (ce) begin
      if (in_run_eff) begin
        if (!pulse_in || eol) state_nxt = IDLE;
      end else begin
        state_nxt = IDLE;
        if (pulse_in && !eol) begin
          state_nxt = IN_RUN;
          start_nxt = x_cur;
          y_run_nxt = y_cur;
        end
      end
    end
  end

  always_comb begin
    close       = 1'b0;
    close_start = run_start;
    close_end   = x_cur;
    close_y     = y_run;
    if (ce) begin
      if (in_run_eff) begin
        if (!pulse_in) begin
          close     = 1'b1;
          close_end = x_cur - 1'b1;
        end else if (eol) begin
          close     = 1'b1;
        end
      end else if (pulse_in && eol) begin
        close       = 1'b1;
        close_start = x_cur;
        close_y     = y_cur;
      end
    end
  end

  // One extra bit so a full-width run (2^X_W pixels) compares correctly.
  assign run_len = {1'b0, close_end} - {1'b0, close_start} + 1'b1;
  assign qualify = close && (run_len >= (X_W+1)'(MIN_RUN));
  assign load    = qualify && (!seg_valid || seg_ready);
  assign drop    = qualify && seg_valid && !seg_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_valid   <= 1'b0;
      seg_x_start <= '0;
      seg_x_end   <= '0;
      seg_y       <= '0;
      overflow    <= 1'b0;
    end else begin
      if (load) begin
        seg_valid   <= 1'b1;
        seg_x_start <= close_start;
        seg_x_end   <= close_end;
        seg_y       <= close_y;
      end else if (seg_ready) begin
        seg_valid   <= 1'b0;
      end
      if (drop)          overflow <= 1'b1;
      else if (ce && sof) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_segment_finder.sv
// Scoreboard bench for line_segment_finder: expected segments are queued as
// stimulus is driven and compared when each output handshake completes.
module tb_line_segment_finder;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           ce = 1'b0, sof = 1'b0, eol = 1'b0, pulse_in = 1'b0;
  logic           seg_ready = 1'b0;
  logic           en1 = 1'b0;
  logic           ce1;
  logic           seg_valid, overflow;
  logic [X_W-1:0] seg_x_start, seg_x_end;
  logic [Y_W-1:0] seg_y;
  logic           seg_valid1, overflow1;
  logic [X_W-1:0] seg_x_start1, seg_x_end1;
  logic [Y_W-1:0] seg_y1;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];

  assign ce1 = ce & en1;

  line_segment_finder #(.X_W(X_W), .Y_W(Y_W), .MIN_RUN(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .sof(sof), .eol(eol), .pulse_in(pulse_in),
    .seg_ready(seg_ready), .seg_valid(seg_valid), .seg_x_start(seg_x_start),
    .seg_x_end(seg_x_end), .seg_y(seg_y), .overflow(overflow)
  );

  line_segment_finder #(.X_W(X_W), .Y_W(Y_W), .MIN_RUN(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce1), .sof(sof), .eol(eol), .pulse_in(pulse_in),
    .seg_ready(1'b1), .seg_valid(seg_valid1), .seg_x_start(seg_x_start1),
    .seg_x_end(seg_x_end1), .seg_y(seg_y1), .overflow(overflow1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seg(input int xs, input int xe, input int y);
    logic [X_W-1:0] a, b;
    logic [Y_W-1:0] c;
    a = xs[X_W-1:0];
    b = xe[X_W-1:0];
    c = y[Y_W-1:0];
    return {a, b, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && seg_valid && seg_ready) begin
      if (exp_q.size() == 0) check("dut_extra_seg", exp_q.size(), 32'd1);
      else check("dut_seg", {seg_x_start, seg_x_end, seg_y}, exp_q.pop_front());
    end
    if (rst && seg_valid1) begin
      if (exp1_q.size() == 0) check("dut1_extra_seg", exp1_q.size(), 32'd1);
      else check("dut1_seg", {seg_x_start1, seg_x_end1, seg_y1}, exp1_q.pop_front());
    end
  end

  task automatic px(input logic s, input logic e, input logic p);
    @(posedge clk); #1;
    ce = 1'b1; sof = s; eol = e; pulse_in = p;
  endtask

  // ce low with random junk on the qualified inputs
  task automatic idle();
    @(posedge clk); #1;
    ce = 1'b0; sof = 1'($urandom); eol = 1'($urandom); pulse_in = 1'($urandom);
  endtask

  task automatic line_a();
    exp_q.push_back(seg(10, 15, 0));
    for (int x = 0; x < 24; x++) begin
      px(x == 0, x == 23, x >= 10 && x <= 15);
      if (x >= 16 && x <= 18) begin
        @(negedge clk);
        check($sformatf("a_valid_x%0d", x), 32'(seg_valid), 32'(x == 17));
      end
    end
    repeat (2) idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(seg_valid), 32'd0);
    check("rst_fields", {seg_x_start, seg_x_end, seg_y}, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_valid1", 32'(seg_valid1), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // basic run, single-cycle valid with ready held high
    idle(); seg_ready = 1'b1;
    line_a();

    // short run filtered at MIN_RUN=4, kept at MIN_RUN=1; single pixel at eol
    idle(); seg_ready = 1'b1; en1 = 1'b1;
    exp1_q.push_back(seg(20, 22, 0));
    exp1_q.push_back(seg(1279, 1279, 0));
    for (int x = 0; x < 1280; x++)
      px(x == 0, x == 1279, (x >= 20 && x <= 22) || x == 1279);
    repeat (3) idle();
    en1 = 1'b0;
    check("b_q1_empty", exp1_q.size(), 32'd0);

    // back-pressure: second run dropped, overflow sticky until sof
    idle(); seg_ready = 1'b0;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 4; x++) px(y == 0 && x == 0, x == 3, 1'b0);
    for (int x = 0; x < 24; x++)
      px(1'b0, x == 23, (x >= 2 && x <= 6) || (x >= 10 && x <= 15));
    repeat (2) idle();
    @(negedge clk);
    check("c_ovf_set", 32'(overflow), 32'd1);
    check("c_valid_held", 32'(seg_valid), 32'd1);
    check("c_fields_held", {seg_x_start, seg_x_end, seg_y}, seg(2, 6, 2));
    exp_q.push_back(seg(2, 6, 2));
    idle(); seg_ready = 1'b1;
    idle(); seg_ready = 1'b0;
    @(negedge clk);
    check("c_valid_acc", 32'(seg_valid), 32'd0);
    check("c_ovf_hold", 32'(overflow), 32'd1);
    px(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("c_ovf_presof", 32'(overflow), 32'd1);
    px(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("c_ovf_clr", 32'(overflow), 32'd0);

    // accept and new close on the same cycle: valid never drops
    idle(); seg_ready = 1'b0;
    exp_q.push_back(seg(2, 6, 0));
    exp_q.push_back(seg(10, 14, 0));
    for (int x = 0; x < 24; x++) begin
      px(x == 0, x == 23, (x >= 2 && x <= 6) || (x >= 10 && x <= 14));
      seg_ready = (x == 15);
      if (x == 15) begin
        @(negedge clk);
        check("d_valid_old", 32'(seg_valid), 32'd1);
        check("d_fields_old", {seg_x_start, seg_x_end, seg_y}, seg(2, 6, 0));
      end
      if (x == 16) begin
        @(negedge clk);
        check("d_valid_new", 32'(seg_valid), 32'd1);
        check("d_fields_new", {seg_x_start, seg_x_end, seg_y}, seg(10, 14, 0));
      end
    end
    idle(); seg_ready = 1'b1;
    idle(); seg_ready = 1'b0;
    @(negedge clk);
    check("d_drained", 32'(seg_valid), 32'd0);
    check("d_ovf", 32'(overflow), 32'd0);

    // ce gaps inside a run do not advance x
    idle(); seg_ready = 1'b1;
    exp_q.push_back(seg(5, 9, 0));
    for (int x = 0; x < 16; x++) begin
      px(x == 0, x == 15, x >= 5 && x <= 9);
      if (x >= 5 && x <= 10) idle();
    end
    repeat (2) idle();

    // sof mid-run discards the open run and starts a new one at x=0
    idle(); seg_ready = 1'b1;
    exp_q.push_back(seg(0, 5, 0));
    for (int x = 0; x < 10; x++) px(x == 0, 1'b0, x >= 3);
    for (int x = 0; x < 12; x++) px(x == 0, x == 11, x <= 5);
    repeat (2) idle();

    // asynchronous reset with a held segment and an open run
    idle(); seg_ready = 1'b0;
    for (int x = 0; x < 13; x++) px(x == 0, 1'b0, (x >= 2 && x <= 6) || x >= 10);
    idle();
    @(negedge clk);
    check("f_held_valid", 32'(seg_valid), 32'd1);
    check("f_held_fields", {seg_x_start, seg_x_end, seg_y}, seg(2, 6, 0));
    @(posedge clk); #3 rst = 1'b0;
    #1;
    check("f_rst_valid", 32'(seg_valid), 32'd0);
    check("f_rst_fields", {seg_x_start, seg_x_end, seg_y}, 32'd0);
    check("f_rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(); seg_ready = 1'b1;
    px(1'b0, 1'b0, 1'b0);
    px(1'b0, 1'b0, 1'b0);
    repeat (2) idle();
    @(negedge clk);
    check("f_no_stale", 32'(seg_valid), 32'd0);
    line_a();

    idle();
    check("q_empty", exp_q.size(), 32'd0);
    check("q1_empty", exp1_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
